btb_pred: RTL and testbench
===========================

# btb_pred

Direct-mapped branch target predictor in the fetch stage, directly upstream of the prediction buffer (BOP). A fetch-address lookup in one cycle yields, in the next cycle, a taken/not-taken decision and predicted target. Every taken prediction redirects fetch and pushes the target into the BOP. The MA stage trains the table through an update port once each transfer of control is resolved.

## Interface
- ENTRIES, 8, table entries; power of two, at least 2; IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry.
- LABEL, "BTB", label passed to the seu_regs storage instances.
- s_clk_i  in  1  clock.
- s_reset_i  in  1  reset; synchronous, active-high.
- s_flush_i  in  1  pipeline flush; kills any in-flight lookup.
- s_lookup_i  in  1  fetch request issued this cycle.
- s_lookup_addr_i  in  32  fetch address.
- s_bop_full_i  in  1  BOP full flag, sampled in the result cycle.
- s_upd_i  in  1  resolved transfer-of-control update from MA.
- s_upd_addr_i  in  32  address of the resolved instruction.
- s_upd_taken_i  in  1  resolved direction.
- s_upd_target_i  in  32  resolved target.
- s_pred_valid_o  out  1  taken prediction; fetch redirects this cycle.
- s_pred_target_o  out  32  predicted target; bit 0 always 0.
- s_bop_push_o  out  1  push to BOP.
- s_bop_data_o  out  BOP_WIDTH  BOP entry, target[31:1] (BOP_WIDTH = 31).

## Operation
- Address split: index = addr[IDX_W+1:2]; tag = addr[IDX_W+TAG_W+1:IDX_W+2].
- Each entry holds: valid, tag[TAG_W], 2-bit counter cnt, target[31:1].
- Lookup cycle t (s_lookup_i=1, s_flush_i=0):
  - Read the entry at the index from pre-update state.
  - Register hit = valid & tag match & cnt[1], together with the target.
- Lookup with s_flush_i=1 is dropped.
- Result cycle t+1: s_pred_valid_o = s_bop_push_o = registered hit & ~s_bop_full_i & ~s_flush_i.
  - s_pred_target_o = {target, 1'b0}.
  - s_bop_data_o = target.
- If the BOP is full, the prediction is suppressed: no redirect and no push. The redirect and the BOP push are always paired.
- Update, written at the end of the s_upd_i cycle:
  - Tag hit, taken: cnt saturating-increment (max 2'b11); target replaced.
  - Tag hit, not taken: cnt saturating-decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate with valid=1, new tag, cnt=2'b10, target = s_upd_target_i[31:1].
  - Miss, not taken: no change.
- Update and lookup in the same cycle, same index: the lookup sees the old entry, then the update writes.
- s_flush_i does not block updates.
- Reset clears all valid bits and the lookup result register. Tag, counter and target arrays are not reset.
- Reset values: s_pred_valid_o=0, s_bop_push_o=0, s_pred_target_o=0, s_bop_data_o=0.
- Reset mid-lookup: the result is discarded; no push follows.
- Reset dominates s_upd_i in the same cycle.

## Timing
- Lookup-to-prediction latency: 1 cycle. Outputs are driven from registered result state plus same-cycle s_bop_full_i and s_flush_i.
- Update-to-visibility: an update in cycle t affects lookups issued in cycle t+1 or later.
- Back-to-back lookups: one per cycle, each producing a result in the following cycle.
- At most one push per cycle. The BOP sees push strictly in cycle t+1 of a lookup.

## Structure
- p_hardisc gains:
  - BOP_WIDTH (31).
  - BTB entry typedef: valid, tag, cnt, target.
  - 2-bit counter constants WEAK_TAKEN=2'b10 and STRONG_TAKEN=2'b11.
  - Saturating-update function.
- Storage instances, all through seu_regs with GROUP 5 for fault injection, one clock:
  - Table arrays: LABEL.
  - Valid vector: LABEL+"VLD".
  - Lookup result register: LABEL+"RES".
- No further sub-module; counter logic uses the package function.

## Test plan
- Reset, then lookup 0x0000_0100 -> next cycle s_pred_valid_o=0, s_bop_push_o=0.
- Update 0x0000_0100, taken, target 0x0000_0400; lookup 0x0000_0100 next cycle -> one cycle later s_pred_valid_o=1, s_pred_target_o=0x0000_0400, s_bop_data_o=0x0000_0200.
- Two not-taken updates on that entry (cnt 10->01->00), then lookup -> no prediction. One taken update (cnt 01) -> still none. A second taken update (cnt 10) -> predicts.
- Aliasing: allocate 0x100, then lookup 0x100 + (ENTRIES*4) (same index, different tag) -> no prediction. A taken update at the alias replaces the entry; lookup 0x100 then misses.
- Hit while s_bop_full_i=1 in the result cycle -> no redirect, no push. Repeated lookup with full=0 -> both asserted.
- Same-cycle update allocate plus lookup of that address -> the lookup misses; a lookup the next cycle hits. s_flush_i in a result cycle, or s_reset_i mid-lookup -> no push.

Source files
------------

// File: rtl/btb_pred_pkg.sv
// Shared types and helpers for the direct-mapped branch target predictor.
// The 2-bit counter predicts taken when its MSB is set.
package btb_pred_pkg;

  localparam int BOP_WIDTH = 31;

  typedef logic [1:0] cnt_t;

  localparam cnt_t STRONG_NOT_TAKEN = 2'b00;
  localparam cnt_t WEAK_TAKEN       = 2'b10;
  localparam cnt_t STRONG_TAKEN     = 2'b11;

  function automatic cnt_t cnt_sat_update(input cnt_t cnt, input logic taken);
    cnt_t res;
    res = cnt;
    if (taken && (cnt != STRONG_TAKEN)) begin
      res = cnt + 2'd1;
    end else if (!taken && (cnt != STRONG_NOT_TAKEN)) begin
      res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/btb_pred_if.sv
// Fetch/MA-side bundle of the branch target predictor: lookup, training update,
// redirect and BOP push.
interface btb_pred_if;
  import btb_pred_pkg::*;

  logic                 s_flush_i;
  logic                 s_lookup_i;
  logic [31:0]          s_lookup_addr_i;
  logic                 s_bop_full_i;
  logic                 s_upd_i;
  logic [31:0]          s_upd_addr_i;
  logic                 s_upd_taken_i;
  logic [31:0]          s_upd_target_i;
  logic                 s_pred_valid_o;
  logic [31:0]          s_pred_target_o;
  logic                 s_bop_push_o;
  logic [BOP_WIDTH-1:0] s_bop_data_o;

  modport master (
    output s_flush_i, s_lookup_i, s_lookup_addr_i, s_bop_full_i,
           s_upd_i, s_upd_addr_i, s_upd_taken_i, s_upd_target_i,
    input  s_pred_valid_o, s_pred_target_o, s_bop_push_o, s_bop_data_o
  );

  modport slave (
    input  s_flush_i, s_lookup_i, s_lookup_addr_i, s_bop_full_i,
           s_upd_i, s_upd_addr_i, s_upd_taken_i, s_upd_target_i,
    output s_pred_valid_o, s_pred_target_o, s_bop_push_o, s_bop_data_o
  );

endinterface

// File: rtl/seu_regs.sv
// Register bank with write enable; labelled, grouped instances are the points
// where fault injection attaches.
module seu_regs #(
  parameter string LABEL = "",
  parameter int    GROUP = 0,
  parameter int    N     = 1
) (
  input  logic         clk,
  input  logic         we,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  if ((GROUP > 0) && (LABEL != "")) begin : g_seu
    always_ff @(posedge clk) begin
      if (we) q <= d;
    end
  end else begin : g_plain
    always_ff @(posedge clk) begin
      if (we) q <= d;
    end
  end

endmodule

// File: rtl/btb_pred.sv
// Direct-mapped BTB: lookup in cycle t, taken prediction and paired BOP push in
// cycle t+1; trained by resolved transfers of control from MA.
module btb_pred
  import btb_pred_pkg::*;
#(
  parameter int    ENTRIES = 8,
  parameter int    TAG_W   = 8,
  parameter string LABEL   = "BTB"
) (
  input logic       s_clk_i,
  input logic       s_reset_i,
  btb_pred_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    cnt_t                 cnt;
    logic [BOP_WIDTH-1:0] target;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
  localparam int RES_W   = BOP_WIDTH + 1;

  logic [IDX_W-1:0]   lk_idx, up_idx;
  logic [TAG_W-1:0]   lk_tag, up_tag;
  entry_t             tbl_q [ENTRIES];
  entry_t             lk_ent, up_ent, wr_ent;
  logic [ENTRIES-1:0] vld_q, vld_d;
  logic               lk_hit, up_tag_hit, up_we;
  logic [RES_W-1:0]   res_d, res_q;
  logic               pred;
  logic               unused_bits;

  assign unused_bits = ^{bus.s_lookup_addr_i, bus.s_upd_addr_i, bus.s_upd_target_i[0]};

  // Lookup stage: reads pre-update state, so a same-cycle update is not seen
  always_comb begin
    lk_idx = bus.s_lookup_addr_i[IDX_W+1:2];
    lk_tag = bus.s_lookup_addr_i[IDX_W+TAG_W+1:IDX_W+2];
    lk_ent = tbl_q[lk_idx];
    lk_hit = bus.s_lookup_i & ~bus.s_flush_i & vld_q[lk_idx]
             & (lk_ent.tag == lk_tag) & lk_ent.cnt[1];
    res_d  = s_reset_i ? '0 : {lk_hit, (lk_hit ? lk_ent.target : {BOP_WIDTH{1'b0}})};
  end

  // Training: reset wins over an update in the same cycle
  always_comb begin
    up_idx     = bus.s_upd_addr_i[IDX_W+1:2];
    up_tag     = bus.s_upd_addr_i[IDX_W+TAG_W+1:IDX_W+2];
    up_ent     = tbl_q[up_idx];
    up_tag_hit = vld_q[up_idx] & (up_ent.tag == up_tag);
    up_we      = bus.s_upd_i & ~s_reset_i & (up_tag_hit | bus.s_upd_taken_i);
    wr_ent     = up_ent;
    if (up_tag_hit) begin
      wr_ent.cnt = cnt_sat_update(up_ent.cnt, bus.s_upd_taken_i);
      if (bus.s_upd_taken_i) wr_ent.target = bus.s_upd_target_i[31:1];
    end else begin
      wr_ent.tag    = up_tag;
      wr_ent.cnt    = WEAK_TAKEN;
      wr_ent.target = bus.s_upd_target_i[31:1];
    end
    vld_d = vld_q;
    if (s_reset_i) begin
      vld_d = '0;
    end else if (up_we) begin
      vld_d = vld_q | (ENTRIES'(1) << up_idx);
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_tbl
    seu_regs #(.LABEL(LABEL), .GROUP(5), .N(ENTRY_W)) u_tbl (
      .clk (s_clk_i),
      .we  (up_we && (up_idx == IDX_W'(i))),
      .d   (wr_ent),
      .q   (tbl_q[i])
    );
  end

  seu_regs #(.LABEL({LABEL, "VLD"}), .GROUP(5), .N(ENTRIES)) u_vld (
    .clk (s_clk_i),
    .we  (1'b1),
    .d   (vld_d),
    .q   (vld_q)
  );

  seu_regs #(.LABEL({LABEL, "RES"}), .GROUP(5), .N(RES_W)) u_res (
    .clk (s_clk_i),
    .we  (1'b1),
    .d   (res_d),
    .q   (res_q)
  );

  // Result stage: redirect and push stay paired, both gated by full and flush
  assign pred                = res_q[RES_W-1] & ~bus.s_bop_full_i & ~bus.s_flush_i;
  assign bus.s_pred_valid_o  = pred;
  assign bus.s_bop_push_o    = pred;
  assign bus.s_pred_target_o = {res_q[BOP_WIDTH-1:0], 1'b0};
  assign bus.s_bop_data_o    = res_q[BOP_WIDTH-1:0];

endmodule

// File: tb/tb_btb_pred.sv
// Directed bench for btb_pred: a cycle table of stimulus with the expected
// outputs of that same cycle, followed by short reset/same-cycle sequences.
module tb_btb_pred;
  import btb_pred_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btb_pred_if bus();

  btb_pred #(.ENTRIES(8), .TAG_W(8), .LABEL("BTB")) dut (
    .s_clk_i   (clk),
    .s_reset_i (rst),
    .bus       (bus.slave)
  );

  typedef struct {
    logic        lk;
    logic [31:0] la;
    logic        up;
    logic [31:0] ua;
    logic        tk;
    logic [31:0] ut;
    logic        full;
    logic        flush;
    logic        ev;
    logic [31:0] et;
  } vec_t;

  vec_t vecs[$];
  int   npass = 0;
  int   ntotal = 0;

  function automatic vec_t mk(logic lk, logic [31:0] la, logic up, logic [31:0] ua,
                              logic tk, logic [31:0] ut, logic full, logic flush,
                              logic ev, logic [31:0] et);
    vec_t v;
    v.lk = lk; v.la = la; v.up = up; v.ua = ua; v.tk = tk; v.ut = ut;
    v.full = full; v.flush = flush; v.ev = ev; v.et = et;
    return v;
  endfunction

  task automatic drive(vec_t v);
    bus.s_lookup_i      = v.lk;
    bus.s_lookup_addr_i = v.la;
    bus.s_upd_i         = v.up;
    bus.s_upd_addr_i    = v.ua;
    bus.s_upd_taken_i   = v.tk;
    bus.s_upd_target_i  = v.ut;
    bus.s_bop_full_i    = v.full;
    bus.s_flush_i       = v.flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Compares this cycle's outputs; target/data only matter when a prediction is made
  task automatic chk(string name, logic ev, logic [31:0] et);
    #1;
    cmp({name, ".valid"}, {31'd0, bus.s_pred_valid_o}, {31'd0, ev});
    cmp({name, ".push"},  {31'd0, bus.s_bop_push_o},   {31'd0, ev});
    if (ev) begin
      cmp({name, ".target"}, bus.s_pred_target_o, et);
      cmp({name, ".data"},   {1'b0, bus.s_bop_data_o}, {1'b0, et[31:1]});
    end
  endtask

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] AL = 32'h0000_0120;

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset", 1'b0, 32'h0);
    cmp("reset.target", bus.s_pred_target_o, 32'h0);
    cmp("reset.data", {1'b0, bus.s_bop_data_o}, 32'h0);

    //            lk la  up ua  tk ut            full flush ev et
    vecs.push_back(mk(1, A0, 0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  1, A0, 1, 32'h400,      0, 0, 0, 0));
    vecs.push_back(mk(1, A0, 0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,            0, 0, 1, 32'h400));
    vecs.push_back(mk(0, 0,  1, A0, 0, 32'hFFF0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  1, A0, 0, 32'hFFF0,     0, 0, 0, 0));
    vecs.push_back(mk(1, A0, 0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  1, A0, 1, 32'h400,      0, 0, 0, 0));
    vecs.push_back(mk(1, A0, 0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  1, A0, 1, 32'h400,      0, 0, 0, 0));
    vecs.push_back(mk(1, A0, 0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,            0, 0, 1, 32'h400));
    vecs.push_back(mk(1, AL, 0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  1, AL, 1, 32'h800,      0, 0, 0, 0));
    vecs.push_back(mk(1, A0, 0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(1, AL, 0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,            0, 0, 1, 32'h800));
    vecs.push_back(mk(1, AL, 0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(1, AL, 0, 0,  0, 0,            1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,            0, 0, 1, 32'h800));
    vecs.push_back(mk(1, AL, 0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,            0, 1, 0, 0));
    vecs.push_back(mk(1, AL, 0, 0,  0, 0,            0, 1, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  1, AL, 1, 32'hA04,      0, 0, 0, 0));
    vecs.push_back(mk(1, AL, 0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,            0, 0, 1, 32'hA04));
    vecs.push_back(mk(0, 0,  1, AL, 0, 32'h7770,     0, 0, 0, 0));
    vecs.push_back(mk(1, AL, 0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,            0, 0, 1, 32'hA04));
    vecs.push_back(mk(1, AL, 0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(1, A0, 0, 0,  0, 0,            0, 0, 1, 32'hA04));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  1, 32'h104, 1, 32'h1235, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h104, 0, 0, 0, 0,        0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,            0, 0, 1, 32'h1234));
    vecs.push_back(mk(0, 0,  1, 32'h108, 0, 32'h500, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h108, 0, 0, 0, 0,        0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,            0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      chk($sformatf("row%0d", i), vecs[i].ev, vecs[i].et);
      tick();
    end

    // Same-cycle allocate and lookup: the lookup sees the old (invalid) entry
    drive(mk(1, 32'h10C, 1, 32'h10C, 1, 32'h2000, 0, 0, 0, 0));
    tick();
    drive(mk(1, 32'h10C, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("same_cycle_miss", 1'b0, 32'h0);
    tick();
    drive(idle);
    chk("next_cycle_hit", 1'b1, 32'h2000);
    tick();

    // Reset during a lookup that would hit: no push follows, entries invalidated
    drive(mk(1, 32'h10C, 1, 32'h110, 1, 32'h3000, 0, 0, 0, 0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(mk(1, 32'h10C, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("reset_mid_lookup", 1'b0, 32'h0);
    tick();
    drive(mk(1, 32'h110, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("reset_clears_valid", 1'b0, 32'h0);
    tick();
    drive(idle);
    chk("reset_beats_update", 1'b0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
